bus_arbiter: RTL
================

// Module: bus_arbiter
// PURPOSE
//   Round-robin arbiter for the shared system bus. Sits directly downstream of the cpu master
//   ports (M0 = instruction fetch, M1 = data access) and of any additional masters (e.g. DMA).
//   Consumes active-low BusReq_/BusAs_ and returns registered active-low BusGrnt_ plus an
//   owner index that steers the downstream address/data master mux.
//   A grant is never revoked mid-transfer. An optional hold limit bounds how long one master keeps the bus.
// PARAMETERS
//   NUM_MASTERS  4   number of bus masters (2..8); index 0 = cpu M0, 1 = cpu M1
//   MAX_HOLD     16  max consecutive owned cycles before forced re-arbitration; 0 = unlimited
// PORTS
//   clk        in   1            system clock, all state on rising edge
//   reset_     in   1            asynchronous active-low reset
//   BusReq_    in   NUM_MASTERS  per-master request, active low
//   BusAs_     in   NUM_MASTERS  per-master address strobe, active low (transfer in flight)
//   BusGrnt_   out  NUM_MASTERS  per-master grant, active low, one-cold or all high, registered
//   Owner      out  clog2(N)     index of current/last owner, registered
//   OwnerVld   out  1            high when some master holds a grant
// BEHAVIOUR
//   Reset: BusGrnt_ all 1, Owner = 0, OwnerVld = 0, hold counter = 0, state IDLE.
//   States: IDLE (no grant) and OWNED (exactly one grant low).
//   IDLE:
//     - Any BusReq_ low -> next edge grant the first requester scanning Owner+1, Owner+2, ...
//       (mod N), ending with Owner itself.
//     - Latency is 1 cycle from request to grant. Go to OWNED, load hold counter = 1.
//   OWNED:
//     - Owner's BusReq_ still low and not preempted: grant held, counter increments
//       (saturates at MAX_HOLD).
//     - Owner's BusReq_ high: release. Next edge, grant the next requester in round-robin order
//       from Owner+1 (stay OWNED, counter = 1). If none is pending, go to IDLE with all grants high.
//     - The releasing master never regains the bus in the same handoff edge if another master is
//       pending. If it is the only requester, it may be re-granted.
//     - Preemption, when MAX_HOLD != 0, requires all of:
//         counter == MAX_HOLD, another master requesting, owner's BusAs_ high.
//       Then the grant moves to the next round-robin requester at the next edge.
//       While owner's BusAs_ is low, preemption waits (grant held, counter saturated).
//   Grant change is break-before-make within one edge:
//     - The old grant goes high and the new grant goes low on the same edge.
//     - Never two grants low at once.
//   Owner keeps its last value in IDLE; it is the round-robin pointer.
//   Requests from non-owners have no effect on grants until release or preemption.
//   Masters deasserting BusReq_ before grant are simply skipped.
//   Reset asserted mid-transfer: all grants high immediately (async), state IDLE; masters must
//   restart.
//   N = 2 degenerates to alternate-on-contention.
//   Counter width is clog2(MAX_HOLD+1), with a minimum of 1.
// STRUCTURE
//   Shared header bus.vh: `BUS_MASTER_CH, `BUS_OWNER_BUS, `BUS_ARB_IDLE/`BUS_ARB_OWNED
//   state encodings, plus the ENABLE_/DISABLE_ active-low constants from stddef.vh.
//   One sub-module: rr_pick (combinational). Inputs are a request vector and a start index.
//   Outputs are a one-hot pick and a found flag.
//   Top level holds the FSM, Owner register, hold counter and grant register.
// TESTING
//   1. After reset: BusGrnt_ = 4'b1111, OwnerVld = 0.
//      Lower BusReq_[1] at cycle 0 -> BusGrnt_ = 4'b1101 and Owner = 1 at cycle 1.
//   2. Masters 0, 2, 3 request continuously while owner 1 releases.
//      Grants go 2 -> 3 -> 0, each handoff 1 cycle after the release edge.
//      Never two grants low at once.
//   3. MAX_HOLD = 4, master 0 holds with BusAs_[0] high and master 3 requests.
//      Grant moves to 3 on the edge after the 4th owned cycle.
//      With BusAs_[0] low, the move is deferred until BusAs_[0] rises.
//   4. Sole requester releases then re-requests.
//      It goes IDLE for 1 cycle, then is re-granted (Owner unchanged).
//   5. Async reset_ pulse mid-grant, not aligned to clk.
//      BusGrnt_ = 4'b1111 and OwnerVld = 0 immediately. Arbitration restarts from Owner = 0.
//   6. MAX_HOLD = 0, two masters contend for 1000 cycles.
//      No preemption occurs. The one-cold invariant is checked every cycle by assertion.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the round-robin system bus arbiter.
// Bus-side grant/request/strobe signals are active low; masters are indexed 0..N-1.
package bus_arbiter_pkg;

   localparam int unsigned MaxMasters = 8;

   localparam logic EnableN  = 1'b0;
   localparam logic DisableN = 1'b1;

   typedef enum logic {
      StIdle  = 1'b0,
      StOwned = 1'b1
   } arb_state_e;

   // Index of the set bit of a one-hot vector; zero when no bit is set.
   function automatic logic [2:0] onehot_to_idx(logic [MaxMasters-1:0] oh);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < int'(MaxMasters); i++) begin
         if (oh[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request scanning upward from start_i, wrapping.
// Produces a one-hot pick and a found flag.
module bus_arbiter_rr_pick #(
   parameter int unsigned NumReq = 4
) (
   input  logic [NumReq-1:0]         req_i,
   input  logic [$clog2(NumReq)-1:0] start_i,
   output logic [NumReq-1:0]         pick_o,
   output logic                      found_o
);

   localparam int unsigned IdxW = $clog2(NumReq);

   always_comb begin
      int idx;
      pick_o  = '0;
      found_o = 1'b0;
      idx     = 0;
      for (int k = 0; k < int'(NumReq); k++) begin
         idx = int'(start_i) + k;
         if (idx >= int'(NumReq)) idx = idx - int'(NumReq);
         if (!found_o && req_i[idx[IdxW-1:0]]) begin
            pick_o[idx[IdxW-1:0]] = 1'b1;
            found_o               = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin system bus arbiter with registered active-low grants, owner index and an
// optional hold limit that forces re-arbitration once the owner's transfer strobe drops.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = 4,
   parameter int unsigned MAX_HOLD    = 16
) (
   input  logic                           clk,
   input  logic                           reset_,
   input  logic [NUM_MASTERS-1:0]         BusReq_,
   input  logic [NUM_MASTERS-1:0]         BusAs_,
   output logic [NUM_MASTERS-1:0]         BusGrnt_,
   output logic [$clog2(NUM_MASTERS)-1:0] Owner,
   output logic                           OwnerVld
);

   localparam int unsigned OwnerW  = $clog2(NUM_MASTERS);
   localparam int unsigned HoldW   = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);

   arb_state_e             state_q, state_d;
   logic [OwnerW-1:0]      owner_q, owner_d;
   logic [HoldW-1:0]       hold_q, hold_d;
   logic [NUM_MASTERS-1:0] grant_n_q, grant_n_d;

   logic [NUM_MASTERS-1:0] req, owner_oh, cand_req, pick;
   logic [MaxMasters-1:0]  pick_ext;
   logic [OwnerW-1:0]      start_idx, pick_idx;
   logic                   found, owner_req, owner_busy, preempt;

   assign req        = ~BusReq_;
   assign owner_oh   = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << owner_q;
   assign owner_req  = req[owner_q];
   assign owner_busy = ~BusAs_[owner_q];
   assign start_idx  = (owner_q == OwnerW'(NUM_MASTERS - 1)) ? '0 : owner_q + OwnerW'(1);
   // While owned, the owner is masked so a release or preemption always hands off to others.
   assign cand_req   = (state_q == StOwned) ? (req & ~owner_oh) : req;
   assign preempt    = (MAX_HOLD != 0) && (hold_q == HoldMax) && found && !owner_busy;

   bus_arbiter_rr_pick #(
      .NumReq (NUM_MASTERS)
   ) u_rr_pick (
      .req_i   (cand_req),
      .start_i (start_idx),
      .pick_o  (pick),
      .found_o (found)
   );

   always_comb begin
      pick_ext                  = '0;
      pick_ext[NUM_MASTERS-1:0] = pick;
      pick_idx                  = OwnerW'(onehot_to_idx(pick_ext));
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      hold_d    = hold_q;
      grant_n_d = grant_n_q;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               state_d   = StOwned;
               owner_d   = pick_idx;
               grant_n_d = ~pick;
               hold_d    = HoldW'(1);
            end
         end
         StOwned: begin
            if (!owner_req || preempt) begin
               if (found) begin
                  owner_d   = pick_idx;
                  grant_n_d = ~pick;
                  hold_d    = HoldW'(1);
               end else begin
                  state_d   = StIdle;
                  grant_n_d = {NUM_MASTERS{DisableN}};
                  hold_d    = '0;
               end
            end else if ((MAX_HOLD != 0) && (hold_q != HoldMax)) begin
               hold_d = hold_q + HoldW'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q   <= StIdle;
         owner_q   <= '0;
         hold_q    <= '0;
         grant_n_q <= {NUM_MASTERS{DisableN}};
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         hold_q    <= hold_d;
         grant_n_q <= grant_n_d;
      end
   end

   assign BusGrnt_ = grant_n_q;
   assign Owner    = owner_q;
   assign OwnerVld = (state_q == StOwned);

endmodule
